// File: rtl/sort_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_frame_ctrl                                              |
// | Description : Frame sequencer for the insertion sorting array. Accepts up  |
// |               to SIZE words over a valid/ready port, feeds them one per    |
// |               cycle into the array, waits for the array outputs to settle, |
// |               drains the filled slots serially, then clears the array.     |
// | Options     : SORT_FRAME_CTRL_DESC_EN - drain largest word first.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sort_frame_ctrl #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Upstream word stream
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WIDTH-1:0]        in_data_i,
  input  logic                    in_last_i,
  // Sorting array control
  output logic                    sort_en_o,
  output logic [WIDTH-1:0]        sort_data_o,
  output logic                    sort_rst_o,
  input  logic [SIZE*WIDTH-1:0]   sorted_bus_i,
  // Downstream sorted stream
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_last_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] C_SIZE = CNT_W'(SIZE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               settle_q, settle_d;
  logic               sort_en_q, sort_en_d;
  logic [WIDTH-1:0]   sort_data_q, sort_data_d;

  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_close;
  logic               w_is_last;
  logic [CNT_W-1:0]   w_len_m1;
  logic [CNT_W-1:0]   w_slot;

  // Handshakes and frame-close detection. in_ready is a pure state decode,
  // so an accept is simply LOAD together with in_valid.
  assign w_in_hs   = (state_q == ST_LOAD) && in_valid_i;
  assign w_out_hs  = (state_q == ST_DRAIN) && out_ready_i;
  assign w_close   = w_in_hs && (in_last_i || ((len_q + 1'b1) == C_SIZE));
  assign w_len_m1  = len_q - 1'b1;
  assign w_is_last = (idx_q == w_len_m1);

  // The drain counter always runs 0..len-1; the emitted slot is mapped from it
  // so the last-word detection is identical in both orders.
`ifdef SORT_FRAME_CTRL_DESC_EN
  assign w_slot = w_len_m1 - idx_q;
`else
  assign w_slot = idx_q;
`endif

  // Next-state and datapath-register logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    sort_en_d   = 1'b0;
    sort_data_d = sort_data_q;

    case (state_q)
      ST_CLEAR: begin
        // Array is being cleared this cycle; start a fresh, empty frame.
        len_d    = '0;
        idx_d    = '0;
        settle_d = 1'b0;
        state_d  = ST_LOAD;
      end

      ST_LOAD: begin
        if (w_in_hs) begin
          len_d       = len_q + 1'b1;
          sort_en_d   = 1'b1;
          sort_data_d = in_data_i;
          if (w_close) begin
            settle_d = 1'b0;
            state_d  = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        // First cycle covers the cell update, second the output register.
        if (settle_q) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          settle_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (w_out_hs) begin
          if (w_is_last) begin
            state_d = ST_CLEAR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State and counter registers; reset discards any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      len_q       <= '0;
      idx_q       <= '0;
      settle_q    <= 1'b0;
      sort_en_q   <= 1'b0;
      sort_data_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      sort_en_q   <= sort_en_d;
      sort_data_q <= sort_data_d;
    end
  end

  // Handshake and array-control outputs are decoded from registered state.
  assign in_ready_o  = (state_q == ST_LOAD);
  assign out_valid_o = (state_q == ST_DRAIN);
  assign sort_rst_o  = (state_q == ST_CLEAR);
  assign sort_en_o   = sort_en_q;
  assign sort_data_o = sort_data_q;
  assign busy_o      = !((state_q == ST_LOAD) && (len_q == '0));
  assign out_last_o  = out_valid_o && w_is_last;

  // Sorted word mux; forced to zero outside DRAIN so idle outputs are quiet.
  assign out_data_o  = out_valid_o ? sorted_bus_i[int'(w_slot)*WIDTH +: WIDTH]
                                   : '0;

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_ctrl.sv
`default_nettype none
module tb_sort_frame_ctrl;

  localparam int SIZE  = 16;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam int NPOOL = 47;
  localparam int NVEC  = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_last;
  logic                  sort_en;
  logic [WIDTH-1:0]      sort_data;
  logic                  sort_rst;
  logic [SIZE*WIDTH-1:0] sorted_bus;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  busy;

  always #5 clk = ~clk;

  sort_frame_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .sort_en_o    (sort_en),
    .sort_data_o  (sort_data),
    .sort_rst_o   (sort_rst),
    .sorted_bus_i (sorted_bus),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .busy_o       (busy)
  );

  // Behavioural insertion sorting array: empty cells hold all-ones, one
  // insertion per enabled cycle, outputs registered once more.
  logic [WIDTH-1:0] cells [SIZE];
  logic [WIDTH-1:0] obus  [SIZE];
  logic [WIDTH-1:0] ins   [SIZE];
  int               ins_pos;

  always_comb begin
    ins     = cells;
    ins_pos = SIZE;
    for (int k = SIZE-1; k >= 0; k--)
      if (cells[k] > sort_data) ins_pos = k;
    for (int k = SIZE-1; k > 0; k--)
      if (k > ins_pos) ins[k] = cells[k-1];
    if (ins_pos < SIZE) ins[ins_pos] = sort_data;
  end

  always @(posedge clk) begin
    if (sort_rst) begin
      for (int k = 0; k < SIZE; k++) cells[k] <= '1;
    end else if (sort_en) begin
      cells <= ins;
    end
    obus <= cells;
  end

  always_comb begin
    sorted_bus = '0;
    for (int k = 0; k < SIZE; k++) sorted_bus[k*WIDTH +: WIDTH] = obus[k];
  end

  // Stimulus pools and frame table.
  logic [WIDTH-1:0] in_pool  [NPOOL];
  logic [WIDTH-1:0] exp_pool [NPOOL];

  typedef struct {
    int         n;
    int         base;
    bit         last;
    logic [3:0] pat;
  } vec_t;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_at(input int base, input int n, input int k);
`ifdef SORT_FRAME_CTRL_DESC_EN
    return exp_pool[base + n - 1 - k];
`else
    return exp_pool[base + k];
`endif
  endfunction

  task automatic send(input int base, input int n, input bit use_last);
    int tmo;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = in_pool[base + i];
      in_last  = use_last && (i == n - 1);
      tmo      = 0;
      while (!in_ready && tmo < 100) begin
        @(posedge clk); #1;
        tmo++;
      end
      check("send_ready", 32'(tmo < 100), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input int base, input int n, input logic [3:0] pat, input string tag);
    int               k;
    int               cyc;
    int               vcyc;
    bit               stall;
    logic [WIDTH-1:0] held;
    k = 0; cyc = 0; vcyc = 0; stall = 1'b0; held = '0;
    while (k < n && cyc < 300) begin
      out_ready = pat[cyc[1:0]];
      if (stall) check({tag, "_hold"}, out_data, held);
      if (out_valid) begin
        vcyc++;
        if (out_ready) begin
          check({tag, "_data"}, out_data, exp_at(base, n, k));
          check({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
          k++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = out_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_count"}, k, n);
    if (pat == 4'hF) check({tag, "_consecutive"}, vcyc, n);
    check({tag, "_clear_rst"}, 32'(sort_rst), 32'd1);
    check({tag, "_clear_novalid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_reload_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_reload_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int got;
    int tmo;

    in_pool = '{7, 3, 9, 1, 5,
                40, 10, 30, 20,
                100, 200,
                50,
                2, 8, 4,
                5, 5, 0, 32'hFFFF_FFFE,
                16, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1,
                80, 20, 60, 40, 10, 70, 30, 50,
                30, 10, 20,
                77};
    exp_pool = '{1, 3, 5, 7, 9,
                 10, 20, 30, 40,
                 100, 200,
                 50,
                 2, 4, 8,
                 0, 5, 5, 32'hFFFF_FFFE,
                 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
                 10, 20, 30, 40, 50, 60, 70, 80,
                 10, 20, 30,
                 77};
    vecs[0] = '{n: 5,  base: 0,  last: 1'b1, pat: 4'b1111};  // short frame
    vecs[1] = '{n: 4,  base: 5,  last: 1'b1, pat: 4'b1001};  // backpressure
    vecs[2] = '{n: 2,  base: 9,  last: 1'b1, pat: 4'b1111};  // frame A
    vecs[3] = '{n: 1,  base: 11, last: 1'b1, pat: 4'b1111};  // frame B
    vecs[4] = '{n: 3,  base: 12, last: 1'b1, pat: 4'b1111};  // 2,8,4
    vecs[5] = '{n: 4,  base: 15, last: 1'b1, pat: 4'b0110};  // duplicates/extremes
    vecs[6] = '{n: 16, base: 19, last: 1'b1, pat: 4'b1111};  // last and full together

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sort_rst",  32'(sort_rst),  32'd1);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_sort_en",   32'(sort_en),   32'd0);
    check("rst_sort_data", sort_data,      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("load_ready", 32'(in_ready), 32'd1);
    check("load_clear", 32'(sort_rst), 32'd0);
    check("load_idle",  32'(busy),     32'd0);

    // Full frame closed by length; a 17th word waits for the next frame.
    send(19, 16, 1'b0);
    check("full_sort_en",   32'(sort_en),  32'd1);
    check("full_sort_data", sort_data,     32'd1);
    check("full_closed",    32'(in_ready), 32'd0);
    check("full_busy",      32'(busy),     32'd1);
    check("full_t1_valid",  32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd77;
    in_last  = 1'b1;
    @(posedge clk); #1;
    check("full_t2_valid",  32'(out_valid), 32'd0);
    check("full_t2_sort_en", 32'(sort_en),  32'd0);
    check("full_t2_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    check("full_t3_valid",  32'(out_valid), 32'd1);
    recv(19, 16, 4'hF, "full");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("extra_sort_en",   32'(sort_en), 32'd1);
    check("extra_sort_data", sort_data,    32'd77);
    recv(46, 1, 4'hF, "extra");

    // Table of frames.
    for (int v = 0; v < NVEC; v++) begin
      send(vecs[v].base, vecs[v].n, vecs[v].last);
      recv(vecs[v].base, vecs[v].n, vecs[v].pat, $sformatf("vec%0d", v));
    end

    // Reset in the middle of draining an 8-word frame.
    send(35, 8, 1'b1);
    out_ready = 1'b1;
    got = 0;
    tmo = 0;
    while (got < 2 && tmo < 50) begin
      if (out_valid) begin
        check("mid_data", out_data, exp_at(35, 8, got));
        got++;
      end
      @(posedge clk); #1;
      tmo++;
    end
    check("mid_got", got, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_last",  32'(out_last),  32'd0);
    check("mid_rst_out_data",  out_data,       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    check("mid_rst_sort_en",   32'(sort_en),   32'd0);
    check("mid_rst_sort_data", sort_data,      32'd0);
    check("mid_rst_sort_rst",  32'(sort_rst),  32'd1);
    check("mid_rst_busy",      32'(busy),      32'd1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    send(43, 3, 1'b1);
    recv(43, 3, 4'hF, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
